// File: rtl/disp_pkg.sv
// Shared types for the display fetch arbiter: FSM states and requester indices.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int REQ_LCD = 0;
  localparam int REQ_VGA = 1;
  localparam int REQ_SPI = 2;

endpackage

// File: rtl/disp_fetch_arb_if.sv
// Requester, memory-command and read-beat signals of the display fetch arbiter.
interface disp_fetch_arb_if #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 24,
  parameter int LW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_urgent;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic               mem_cmd_valid;
  logic               mem_cmd_ready;
  logic [AW-1:0]      mem_cmd_addr;
  logic [LW-1:0]      mem_cmd_len;
  logic               mem_rvalid;
  logic               mem_rlast;
  logic [DW-1:0]      mem_rdata;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;
  logic               rd_last;
  logic               busy;

  modport master (
    input  req_valid, req_urgent, req_addr, req_len,
    output req_ready,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
    input  mem_cmd_ready,
    input  mem_rvalid, mem_rlast, mem_rdata,
    output rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    output req_valid, req_urgent, req_addr, req_len,
    input  req_ready,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
    output mem_cmd_ready,
    output mem_rvalid, mem_rlast, mem_rdata,
    input  rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/disp_fetch_arb_rr_pick.sv
// Combinational round-robin picker: first set mask bit strictly after ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int  j;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    // i == NREQ lands back on ptr itself, so the last winner is considered last
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && mask[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/disp_fetch_arb.sv
// Display line-fetch arbiter: round-robin grant, one memory burst at a time, beats routed to owner.
// Optional urgent-first arbitration is enabled by defining DISP_ARB_URGENT_EN.
module disp_fetch_arb
  import disp_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int DW   = 24,
  parameter int LW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  disp_fetch_arb_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [LW-1:0]   cnt;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            grant_en;
  logic            beat;
  logic            burst_end;

`ifdef DISP_ARB_URGENT_EN
  logic [NREQ-1:0] urgent_set;
  assign urgent_set = bus.req_valid & bus.req_urgent;
  assign cand       = (|urgent_set) ? urgent_set : bus.req_valid;
`else
  assign cand = bus.req_valid;
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .mask  (cand),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Accept strobe is combinational so it can only ever appear while idle
  assign grant_en      = (state == ST_IDLE) && !rst && (|cand);
  assign bus.req_ready = grant_en ? pick_grant : '0;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.mem_cmd_valid = (state == ST_CMD);

  assign beat      = (state == ST_DATA) && bus.mem_rvalid;
  assign burst_end = beat && ((cnt == bus.mem_cmd_len) || bus.mem_rlast);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (grant_en)          state_nx = ST_CMD;
      ST_CMD:  if (bus.mem_cmd_ready) state_nx = ST_DATA;
      ST_DATA: if (burst_end)         state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      ptr              <= IW'(NREQ - 1);
      owner            <= '0;
      cnt              <= '0;
      bus.mem_cmd_addr <= '0;
      bus.mem_cmd_len  <= '0;
      bus.rd_valid     <= '0;
      bus.rd_data      <= '0;
      bus.rd_last      <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_en) begin
        ptr              <= pick_idx;
        owner            <= pick_idx;
        cnt              <= '0;
        bus.mem_cmd_addr <= bus.req_addr[pick_idx*AW +: AW];
        bus.mem_cmd_len  <= bus.req_len[pick_idx*LW +: LW];
      end
      // Read beat stage: one-cycle registered forward to the owning requester
      bus.rd_valid <= beat ? (NREQ'(1) << owner) : '0;
      bus.rd_last  <= burst_end;
      if (beat) begin
        bus.rd_data <= bus.mem_rdata;
        cnt         <= burst_end ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_fetch_arb.sv
// Randomized bench for disp_fetch_arb against a transaction-level arbitration/burst model.
module tb_disp_fetch_arb;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 24;
  localparam int LW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  disp_fetch_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) bus ();

  disp_fetch_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int last_grant = NREQ - 1;

  logic [NREQ-1:0] pend_v = '0;
  logic [DW-1:0]   pend_d = '0;
  logic            pend_l = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Rule: candidates are valid requesters (urgent ones only, if any, when enabled);
  // winner is the first candidate found stepping upward from the last grant.
  function automatic int ref_winner(input logic [2:0] v, input logic [2:0] u);
    logic [2:0] c;
    c = v;
`ifdef DISP_ARB_URGENT_EN
    if ((v & u) != 3'b000) c = v & u;
`else
    if (u == 3'b111) c = v;
`endif
    for (int k = 1; k <= NREQ; k++)
      if (c[(last_grant + k) % NREQ]) return (last_grant + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.req_valid  = 3'($urandom);
    bus.req_urgent = 3'($urandom);
    bus.req_addr   = {$urandom, $urandom, $urandom};
    bus.req_len    = 24'($urandom);
    bus.mem_rvalid = 1'($urandom);
    bus.mem_rlast  = 1'($urandom);
    bus.mem_rdata  = 24'($urandom);
    bus.mem_cmd_ready = 1'($urandom);
  endtask

  task automatic chk_rd();
    chk("rd_valid", 64'(bus.rd_valid), 64'(pend_v));
    chk("rd_last", 64'(bus.rd_last), 64'(pend_l));
    if (pend_v != '0) chk("rd_data", 64'(bus.rd_data), 64'(pend_d));
    pend_v = '0;
    pend_l = 1'b0;
  endtask

  task automatic reset_check();
    step();
    rst = 1'b0;
    bus.req_valid  = '0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rlast  = 1'b1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_cmd_valid", 64'(bus.mem_cmd_valid), 64'd0);
    chk("rst_cmd_addr", 64'(bus.mem_cmd_addr), 64'd0);
    chk("rst_cmd_len", 64'(bus.mem_cmd_len), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_last", 64'(bus.rd_last), 64'd0);
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    pend_v = '0;
    pend_l = 1'b0;
    last_grant = NREQ - 1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.mem_rvalid = 1'b0;
    step();
    step();
    reset_check();
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      step();
      scramble();
      bus.req_valid = '0;
      #1;
      chk_rd();
      chk("idle_req_ready", 64'(bus.req_ready), 64'd0);
      chk("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic xact(input logic [2:0] v, input logic [2:0] u, input int force_len,
                      input int stall, input int rlast_at, input int abort_at,
                      output logic [2:0] rr_o);
    int w, n, alen;
    logic [AW-1:0] aaddr;
    logic [DW-1:0] d;
    step();
    scramble();
    bus.req_valid  = v;
    bus.req_urgent = u;
    for (int k = 0; k < NREQ; k++)
      bus.req_len[k*LW +: LW] = (force_len >= 0) ? LW'(force_len) : LW'($urandom_range(0, 5));
    #1;
    chk_rd();
    w = ref_winner(v, u);
    rr_o = bus.req_ready;
    chk("grant", 64'(bus.req_ready), 64'(3'b001 << w));
    chk("busy_at_grant", 64'(bus.busy), 64'd0);
    last_grant = w;
    alen  = int'(bus.req_len[w*LW +: LW]);
    aaddr = bus.req_addr[w*AW +: AW];
    for (int s = 0; s <= stall; s++) begin
      step();
      scramble();
      bus.mem_cmd_ready = (s == stall);
      #1;
      chk_rd();
      chk("cmd_valid", 64'(bus.mem_cmd_valid), 64'd1);
      chk("cmd_addr", 64'(bus.mem_cmd_addr), 64'(aaddr));
      chk("cmd_len", 64'(bus.mem_cmd_len), 64'(alen));
      chk("cmd_req_ready", 64'(bus.req_ready), 64'd0);
      chk("cmd_busy", 64'(bus.busy), 64'd1);
    end
    n = alen + 1;
    if (rlast_at >= 0 && rlast_at < n) n = rlast_at + 1;
    for (int b = 0; b < n; b++) begin
      if (b == abort_at) begin
        step();
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.mem_rvalid = 1'b1;
        #1;
        chk_rd();
        reset_check();
        return;
      end
      repeat ($urandom_range(0, 1)) begin
        step();
        scramble();
        bus.mem_rvalid = 1'b0;
        #1;
        chk_rd();
        chk("data_req_ready", 64'(bus.req_ready), 64'd0);
        chk("data_busy", 64'(bus.busy), 64'd1);
        chk("data_cmd_valid", 64'(bus.mem_cmd_valid), 64'd0);
      end
      step();
      scramble();
      bus.mem_rvalid = 1'b1;
      bus.mem_rlast  = (b == rlast_at);
      d = bus.mem_rdata;
      #1;
      chk_rd();
      chk("beat_req_ready", 64'(bus.req_ready), 64'd0);
      chk("beat_busy", 64'(bus.busy), 64'd1);
      pend_v = 3'b001 << w;
      pend_d = d;
      pend_l = (b == n - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rr;
    int order[6] = '{0, 1, 2, 0, 1, 2};
    bus.req_valid = '0; bus.req_urgent = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.mem_cmd_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0; bus.mem_rdata = '0;

    do_reset();

    // Single VGA request, four beats
    xact(3'b010, 3'b000, 3, 0, -1, -1, rr);
    chk("c1_grant", 64'(rr), 64'(3'b010));
    idle_cycles(1);

    // All requesting continuously: 0,1,2,0,1,2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      xact(3'b111, 3'b000, -1, 0, -1, -1, rr);
      chk("c2_order", 64'(rr), 64'(3'b001 << order[i]));
    end

    // Lone requester wins back-to-back
    for (int i = 0; i < 2; i++) begin
      xact(3'b001, 3'b000, -1, 0, -1, -1, rr);
      chk("solo_b2b", 64'(rr), 64'(3'b001));
    end

    // Command stalled for 5 cycles
    xact(3'b100, 3'b000, 2, 5, -1, -1, rr);

    // Early mem_rlast on the second beat of an 8-beat burst
    xact(3'b001, 3'b000, 7, 0, 1, -1, rr);
    idle_cycles(2);

    // Reset after two of eight beats, then stray beats
    xact(3'b010, 3'b000, 7, 0, -1, 2, rr);
    idle_cycles(3);

`ifdef DISP_ARB_URGENT_EN
    do_reset();
    xact(3'b111, 3'b100, -1, 0, -1, -1, rr);
    chk("c6_urgent", 64'(rr), 64'(3'b100));
    idle_cycles(1);
`endif

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
      xact(3'($urandom_range(1, 7)), 3'($urandom), -1, $urandom_range(0, 2),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1, -1, rr);
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_fetch_arb.md
DISP_FETCH_ARB -- requirements
Module: disp_fetch_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of display requesters (0=LCD, 1=VGA, 2=SPI LCD).
REQ-002 SHALL have parameter AW, default 32: memory address width.
REQ-003 SHALL have parameter DW, default 24: pixel data width (RGB888).
REQ-004 SHALL have parameter LW, default 8: burst-length field width, beats = len+1.
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  NREQ  per-requester line-fetch request.
REQ-008 SHALL have port req_urgent  in  NREQ  per-requester FIFO-low flag.
REQ-009 SHALL have port req_addr  in  NREQ*AW  packed start addresses.
REQ-010 SHALL have port req_len  in  NREQ*LW  packed burst lengths minus one.
REQ-011 SHALL have port req_ready  out  NREQ  one-hot request accept strobe.
REQ-012 SHALL have port mem_cmd_valid/mem_cmd_ready  out/in  1/1  memory command handshake.
REQ-013 SHALL have port mem_cmd_addr/mem_cmd_len  out  AW/LW  memory command payload.
REQ-014 SHALL have port mem_rvalid/mem_rlast/mem_rdata  in  1/1/DW  memory read beats.
REQ-015 SHALL have port rd_valid  out  NREQ  one-hot beat strobe to owning requester.
REQ-016 SHALL have port rd_data/rd_last  out  DW/1  beat payload, shared by all requesters.
REQ-017 SHALL have port busy  out  1  high outside IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> CMD -> DATA -> IDLE.
REQ-019 IDLE: with any req_valid set, SHALL select a winner, latch its index/addr/len, pulse its req_ready for exactly one cycle, and enter CMD the next cycle.
REQ-020 Winner selection SHALL be round-robin, searching upward (with wrap) from the index after the last granted one; the pointer resets to NREQ-1 so index 0 wins first.
REQ-021 CMD: SHALL hold mem_cmd_valid high with stable addr/len until mem_cmd_ready; the handshake cycle SHALL move to DATA.
REQ-022 DATA: each mem_rvalid SHALL produce a registered rd_valid[owner], rd_data and rd_last one cycle later (latency 1); no other requester sees rd_valid.
REQ-023 SHALL count beats internally; DATA SHALL exit to IDLE on the beat where count == len or mem_rlast, whichever comes first; rd_last SHALL be asserted on that beat.
REQ-024 Beats with mem_rvalid outside DATA SHALL be discarded with no rd_valid.
REQ-025 Requests arriving during CMD/DATA SHALL wait; req_ready SHALL never assert outside IDLE.
REQ-026 A requester dropping req_valid before grant SHALL simply lose arbitration; there is no request latching.
REQ-027 A single requester SHALL be able to win back-to-back grants if it is the only requester.
REQ-028 Minimum grant-to-grant spacing SHALL be 3 cycles (IDLE, CMD, at least one DATA beat).

Reset
REQ-029 With rst high at a rising edge: state=IDLE, RR pointer=NREQ-1, beat counter=0, and req_ready, mem_cmd_valid, rd_valid, rd_last, busy all 0; rd_data and mem_cmd_addr/len SHALL be 0.
REQ-030 Reset mid-burst SHALL abandon the burst; remaining memory beats SHALL be discarded per REQ-024.

Configuration
REQ-031 With DISP_ARB_URGENT_EN defined, requesters with req_valid and req_urgent both set SHALL form the candidate set (round-robin among them); if none are urgent, all valid requesters compete.
REQ-032 Without DISP_ARB_URGENT_EN, req_urgent SHALL be ignored and pure round-robin SHALL apply.

Structure
REQ-033 The shared package disp_pkg SHALL hold the FSM state enum and requester index constants REQ_LCD=0, REQ_VGA=1 and REQ_SPI=2.
REQ-034 The round-robin picker SHALL be a sub-module rr_pick (inputs: candidate mask and pointer; outputs: one-hot grant and index), and SHALL be combinational.

Verification
REQ-035 Case 1, reset then only req_valid=3'b010, len=3: SHALL give req_ready=3'b010 for 1 cycle, one mem command, and 4 rd_valid=3'b010 beats with rd_last on the 4th.
REQ-036 Case 2, req_valid=3'b111 held continuously: grants SHALL occur in order 0,1,2,0,1,2.
REQ-037 Case 3, mem_cmd_ready held low for 5 cycles: mem_cmd_valid and addr SHALL stay stable and there SHALL be no rd_valid.
REQ-038 Case 4, mem_rlast at beat 2 with len=7: burst SHALL end with rd_last on beat 2 and return to IDLE.
REQ-039 Case 5, rst asserted after 2 of 8 beats: all outputs SHALL be 0 next cycle and stray beats SHALL give no rd_valid.
REQ-040 Case 6, with DISP_ARB_URGENT_EN, req_valid=3'b111 and req_urgent=3'b100: SHALL grant requester 2 first.
